// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the multi-channel LED pattern generator:
// channel modes, burst sub-states and the gap length.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    P_ON  = 2'd0,
    P_OFF = 2'd1,
    GAP   = 2'd2
  } bstate_e;

  localparam int GAP_HALVES = 4;

  function automatic int chan_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Per-channel configuration port: valid/ready transfer plus an error pulse
// for out-of-range channel indices.
interface led_pattern_gen_if #(
  parameter int CH_W     = 1,
  parameter int PERIOD_W = 10,
  parameter int BURST_W  = 3
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_chan;
  logic [1:0]          cfg_mode;
  logic [PERIOD_W-1:0] cfg_half;
  logic [BURST_W-1:0]  cfg_count;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_mode, cfg_half, cfg_count,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_mode, cfg_half, cfg_count,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: latched configuration, tick-driven phase counter and the
// blink/burst state machine; the LED bit is registered.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int PERIOD_W = 10,
  parameter int BURST_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic                sync_i,
  input  logic                load_i,
  input  logic [1:0]          mode_i,
  input  logic [PERIOD_W-1:0] half_i,
  input  logic [BURST_W-1:0]  count_i,
  output logic                led_o
);
  // Two extra bits hold GAP_HALVES * half without overflow.
  localparam int PH_W = PERIOD_W + 2;

  mode_e               mode_q, mode_d;
  bstate_e             st_q, st_d;
  logic [PERIOD_W-1:0] half_q, half_d;
  logic [BURST_W-1:0]  count_q, count_d, idx_q, idx_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic                led_q, led_d;

  logic [PH_W-1:0]     limit;
  logic                phase_done;
  logic                last_flash;

  always_comb begin
    limit      = (st_q == GAP) ? PH_W'(half_q) * PH_W'(GAP_HALVES) : PH_W'(half_q);
    phase_done = (phase_q + PH_W'(1)) >= limit;
    last_flash = ({1'b0, idx_q} + (BURST_W + 1)'(1)) >= {1'b0, count_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      st_q    <= P_ON;
      half_q  <= PERIOD_W'(1);
      count_q <= BURST_W'(1);
      idx_q   <= '0;
      phase_q <= '0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      st_q    <= st_d;
      half_q  <= half_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    st_d    = st_q;
    half_d  = half_q;
    count_d = count_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    if (load_i) begin
      mode_d  = mode_e'(mode_i);
      half_d  = (half_i == '0) ? PERIOD_W'(1) : half_i;
      count_d = count_i;
      idx_d   = '0;
      phase_d = '0;
      st_d    = P_ON;
    end else if (sync_i) begin
      idx_d   = '0;
      phase_d = '0;
      st_d    = P_ON;
    end else if (tick_i && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
      if (!phase_done) begin
        phase_d = phase_q + PH_W'(1);
      end else begin
        phase_d = '0;
        case (st_q)
          P_ON:  st_d = P_OFF;
          P_OFF: begin
            // BLINK simply alternates P_ON/P_OFF and never reaches GAP.
            if (mode_q == MODE_BLINK) begin
              st_d = P_ON;
            end else if (last_flash) begin
              st_d = GAP;
            end else begin
              st_d  = P_ON;
              idx_d = idx_q + BURST_W'(1);
            end
          end
          default: begin
            st_d  = P_ON;
            idx_d = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    led_d = 1'b0;
    case (mode_d)
      MODE_ON:    led_d = 1'b1;
      MODE_BLINK: led_d = (st_d == P_ON);
      MODE_BURST: led_d = (st_d == P_ON) && (count_d != '0);
      default:    led_d = 1'b0;
    endcase
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler, configuration
// handshake/decode and one led_channel per LED.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter  int NUM_LEDS = 2,
  parameter  int PRESCALE = 50000,
  parameter  int PERIOD_W = 10,
  parameter  int BURST_W  = 3,
  localparam int CH_W     = chan_width(NUM_LEDS)
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  led_pattern_gen_if.slave    cfg,
  input  logic                sync,
  output logic                tick,
  output logic [NUM_LEDS-1:0] LEDG
);
  localparam int             PS_W     = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CH_W:0]  NUM_CH_C = (CH_W + 1)'(NUM_LEDS);

  logic [PS_W-1:0] cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            accept;
  logic            bad_chan;

  assign tick     = (cnt_q == PS_LAST);
  assign accept   = cfg.cfg_valid & ready_q;
  assign bad_chan = {1'b0, cfg.cfg_chan} >= NUM_CH_C;

  // Ready drops for exactly one cycle after each accepted transfer.
  always_comb begin
    cnt_d   = (sync || tick) ? '0 : cnt_q + PS_W'(1);
    ready_d = ~accept;
    err_d   = accept & bad_chan;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
    logic load;
    assign load = accept && (cfg.cfg_chan == CH_W'(gi));

    led_channel #(
      .PERIOD_W (PERIOD_W),
      .BURST_W  (BURST_W)
    ) u_chan (
      .clk     (CLOCK_50),
      .rst_n   (RESET_N),
      .tick_i  (tick),
      .sync_i  (sync),
      .load_i  (load),
      .mode_i  (cfg.cfg_mode),
      .half_i  (cfg.cfg_half),
      .count_i (cfg.cfg_count),
      .led_o   (LEDG[gi])
    );
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised multi-channel LED pattern generator; successor to the single fixed-rate blinker.
- One shared prescaler feeds NUM_LEDS independent channels. Each channel is set at run time to one of four modes: OFF, ON, BLINK, or BURST (N flashes then a gap).
- Sits between board I/O (LEDG) and any control logic that writes per-channel configuration through a valid/ready port.

Parameters:
- NUM_LEDS, 2, number of LED channels (width of LEDG).
- PRESCALE, 50000, CLOCK_50 cycles per tick (1 kHz at 50 MHz); must be >= 2.
- PERIOD_W, 10, width of the half-period field, counted in ticks.
- BURST_W, 3, width of the burst flash-count field.
- CH_W, max(1, clog2(NUM_LEDS)), derived width of the channel index.

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration can be accepted.
- cfg_chan  in  CH_W  target channel.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cfg_half  in  PERIOD_W  half-period in ticks.
- cfg_count  in  BURST_W  flashes per burst.
- cfg_err  out  1  one-cycle pulse when cfg_chan >= NUM_LEDS.
- sync  in  1  phase-realign all channels.
- tick  out  1  prescaler strobe (debug).
- LEDG  out  NUM_LEDS  LED drive, registered.

Behaviour:
- Clock and reset: one clock, CLOCK_50. RESET_N is asynchronous, active-low, and applies to every flop.
- Reset values:
  - LEDG=0, tick=0, cfg_ready=1, cfg_err=0.
  - All channels: mode OFF, half=1, count=1, phase counters 0.
  - Prescaler count 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 for exactly the one cycle in which count==PRESCALE-1.
- Configuration handshake:
  - A transfer is accepted when cfg_valid & cfg_ready.
  - cfg_ready goes low for the single cycle after an accept, then returns high. Maximum rate is one accept every 2 cycles.
  - cfg_valid held while cfg_ready=0 is not accepted.
  - cfg_chan >= NUM_LEDS: the transfer is accepted, no channel changes, and cfg_err pulses in the cycle after the accept.
- Applying a configuration:
  - The target channel latches mode, half and count, clears its phase counter and burst index, and enters its initial state.
  - LEDG reflects the initial state in the cycle after the accept.
  - cfg_half=0 is treated as 1. For BURST, cfg_count=0 makes the channel behave as OFF.
- Channel state machine (advances only on tick):
  - OFF: LEDG[i]=0.
  - ON: LEDG[i]=1.
  - BLINK: initial state LED=1. Every half ticks, LED toggles and the phase counter clears. Period is 2*half*PRESCALE clocks at 50% duty.
  - BURST: states P_ON, P_OFF, GAP; initial state P_ON, LED=1, idx=0.
    - P_ON → P_OFF after half ticks (LED=0).
    - P_OFF → P_ON after half ticks, idx+1 (LED=1), while idx+1 < count; otherwise → GAP.
    - GAP: LED=0 for GAP_HALVES*half ticks, then → P_ON with idx=0.
- Output timing: all LED changes appear in the clock cycle after the tick that causes them.
- sync:
  - Clears the prescaler and every channel's phase counter and burst index.
  - BLINK and BURST channels re-enter their initial state (LED=1) on the next cycle.
  - OFF and ON channels are unaffected.
  - sync has priority over a coincident tick.
  - If sync coincides with a cfg accept, the new configuration is applied and is also phase-aligned.
- Reset mid-operation: LEDG clears immediately (asynchronous). After release, outputs restart from the reset state.
- Width rules:
  - Phase counter is PERIOD_W+2 bits so the GAP duration cannot overflow.
  - All comparisons are unsigned.

Decomposition:
- Package led_pattern_pkg holds:
  - mode constants MODE_OFF/ON/BLINK/BURST (2-bit);
  - burst state encodings P_ON/P_OFF/GAP;
  - GAP_HALVES=4.
- Sub-module led_channel: one channel's config registers, phase counter and burst FSM. Inputs: tick, sync, load strobe, cfg fields. Output: one LED bit.
- Top level: prescaler, cfg handshake/decode, and a generate loop over NUM_LEDS.

Test Plan (bench uses PRESCALE=4, NUM_LEDS=3, PERIOD_W=4, BURST_W=3):
1. Reset → LEDG=000, cfg_ready=1. Release reset → tick pulses every 4th clock. Assert RESET_N=0 mid-run → LEDG=000 immediately.
2. cfg ch0 BLINK half=3 → LEDG[0]=1 the cycle after accept, then toggles every 12 clocks; LEDG[2:1] stay 00.
3. cfg ch1 BURST half=1 count=2 → LEDG[1] per tick: 1,0,1,0, then four 0s, repeating; ch0 pattern undisturbed.
4. Back-to-back cfg_valid → cfg_ready low for exactly one cycle after each accept. cfg_chan=3 → cfg_err pulses once and LEDG is unchanged.
5. ch0 BLINK half=2 and ch2 BLINK half=5 running, then pulse sync → both LEDs =1 the next cycle with the prescaler restarted; a tick coincident with sync is ignored.
6. cfg ch2 ON, then half=0 BLINK, then BURST count=0 → LEDG[2]=1, then toggles every tick, then constant 0.
